// File: rtl/rf_writeback_arbiter_if.sv
// Writeback bundle: ALU/LSU result handshakes, issue/flush, busy queries and RF write port.
interface rf_writeback_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  alu_valid;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic                  issue_en;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic                  rs1_busy;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic                  rs2_busy;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  issue_en, issue_rd, flush, rs1_addr, rs2_addr,
    output alu_ready, lsu_ready, rs1_busy, rs2_busy,
    output rf_wen, rf_waddr, rf_wdata
  );

  // Pipeline / register-file side
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output issue_en, issue_rd, flush, rs1_addr, rs2_addr,
    input  alu_ready, lsu_ready, rs1_busy, rs2_busy,
    input  rf_wen, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Writeback arbiter: round-robin ALU/LSU onto one registered RF write port,
// plus a per-register busy scoreboard for issue-stage operand stalls.
module rf_writeback_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic                    clk,
  input logic                    rst,
  rf_writeback_arbiter_if.slave  wb
);
  localparam int NREG = 2**ADDR_WIDTH;

  typedef enum logic {PRIO_LSU, PRIO_ALU} prio_e;

  prio_e                 prio_q, prio_d;
  logic [NREG-1:0]       busy_q, busy_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  accept_open;
  logic                  grant_alu, grant_lsu;

  // Grant selection and priority rotation; only a contested grant flips priority
  always_comb begin
    accept_open = !rst && !wb.flush;
    grant_alu   = accept_open && wb.alu_valid && (!wb.lsu_valid || prio_q == PRIO_ALU);
    grant_lsu   = accept_open && wb.lsu_valid && (!wb.alu_valid || prio_q == PRIO_LSU);
    prio_d      = prio_q;
    if (grant_alu && wb.lsu_valid) begin
      prio_d = PRIO_LSU;
    end else if (grant_lsu && wb.alu_valid) begin
      prio_d = PRIO_ALU;
    end
  end

  // Next output write; rd==0 is accepted but never enables the RF write
  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (grant_alu) begin
      wen_d   = |wb.alu_rd;
      waddr_d = wb.alu_rd;
      wdata_d = wb.alu_data;
    end else if (grant_lsu) begin
      wen_d   = |wb.lsu_rd;
      waddr_d = wb.lsu_rd;
      wdata_d = wb.lsu_data;
    end
  end

  // Scoreboard next state: clear on commit, then set on issue so a same-edge set wins
  always_comb begin
    busy_d = busy_q;
    if (wen_q) begin
      busy_d[waddr_q] = 1'b0;
    end
    if (wb.issue_en && !wb.flush && (wb.issue_rd != '0)) begin
      busy_d[wb.issue_rd] = 1'b1;
    end
    if (wb.flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q  <= PRIO_LSU;
      busy_q  <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      prio_q  <= prio_d;
      busy_q  <= busy_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign wb.alu_ready = grant_alu;
  assign wb.lsu_ready = grant_lsu;
  assign wb.rs1_busy  = busy_q[wb.rs1_addr];
  assign wb.rs2_busy  = busy_q[wb.rs2_addr];
  assign wb.rf_wen    = wen_q;
  assign wb.rf_waddr  = waddr_q;
  assign wb.rf_wdata  = wdata_q;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Self-checking bench for rf_writeback_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_rf_writeback_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NREG = 2**AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_writeback_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb();
  rf_writeback_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .wb (wb)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_busy [NREG];
  bit          m_prio_alu;
  bit          m_wen;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int          m_winner;   // 0 none, 1 ALU, 2 LSU
  bit          settled = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int pick();
    if (rst || wb.flush) return 0;
    if (wb.alu_valid && wb.lsu_valid) return m_prio_alu ? 1 : 2;
    if (wb.alu_valid) return 1;
    if (wb.lsu_valid) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_prio_alu = 1'b0;
    for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
  endtask

  task automatic idle();
    wb.alu_valid = 0; wb.alu_rd = '0; wb.alu_data = '0;
    wb.lsu_valid = 0; wb.lsu_rd = '0; wb.lsu_data = '0;
    wb.issue_en = 0; wb.issue_rd = '0; wb.flush = 0;
    wb.rs1_addr = '0; wb.rs2_addr = '0;
  endtask

  task automatic settle();
    #3;
    settled = 1'b1;
  endtask

  // Compare every output against the model mid-cycle, then advance model and clock
  task automatic tick();
    if (!settled) #3;
    m_winner = pick();
    chk("alu_ready", wb.alu_ready, m_winner == 1);
    chk("lsu_ready", wb.lsu_ready, m_winner == 2);
    chk("rs1_busy", wb.rs1_busy, m_busy[wb.rs1_addr]);
    chk("rs2_busy", wb.rs2_busy, m_busy[wb.rs2_addr]);
    chk("rf_wen", wb.rf_wen, m_wen);
    if (m_wen) begin
      chk("rf_waddr", wb.rf_waddr, m_waddr);
      chk("rf_wdata", wb.rf_wdata, m_wdata);
    end
    if (rst) begin
      model_reset();
    end else begin
      if (m_wen) m_busy[m_waddr] = 1'b0;
      if (wb.issue_en && !wb.flush && wb.issue_rd != 0) m_busy[wb.issue_rd] = 1'b1;
      if (wb.flush) for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      if (m_winner == 1) begin
        if (wb.lsu_valid) m_prio_alu = 1'b0;
        m_wen = (wb.alu_rd != 0); m_waddr = wb.alu_rd; m_wdata = wb.alu_data;
      end else if (m_winner == 2) begin
        if (wb.alu_valid) m_prio_alu = 1'b1;
        m_wen = (wb.lsu_rd != 0); m_waddr = wb.lsu_rd; m_wdata = wb.lsu_data;
      end else begin
        m_wen = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    settled = 1'b0;
  endtask

  logic [DW-1:0] exp_data [4];
  bit            exp_lsu  [4];
  bit            ah, lh;
  int            ai, li;

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    model_reset();

    // 1: reset, readies held low even with both sources valid
    wb.alu_valid = 1; wb.lsu_valid = 1; wb.rs1_addr = 5'd1; wb.rs2_addr = 5'd2;
    settle();
    chk("rst_rf_wen", wb.rf_wen, 0);
    chk("rst_rf_waddr", wb.rf_waddr, 0);
    chk("rst_rf_wdata", wb.rf_wdata, 0);
    chk("rst_alu_ready", wb.alu_ready, 0);
    chk("rst_lsu_ready", wb.lsu_ready, 0);
    chk("rst_rs1_busy", wb.rs1_busy, 0);
    tick();
    tick();
    rst = 1'b0;
    idle();

    // 2: issue x5, ALU writes x5
    wb.issue_en = 1; wb.issue_rd = 5'd5;
    tick();
    idle();
    wb.alu_valid = 1; wb.alu_rd = 5'd5; wb.alu_data = 32'hDEADBEEF; wb.rs1_addr = 5'd5;
    settle();
    chk("t2_alu_ready", wb.alu_ready, 1);
    chk("t2_busy_before", wb.rs1_busy, 1);
    tick();
    wb.alu_valid = 0;
    settle();
    chk("t2_rf_wen", wb.rf_wen, 1);
    chk("t2_rf_waddr", wb.rf_waddr, 5);
    chk("t2_rf_wdata", wb.rf_wdata, 32'hDEADBEEF);
    chk("t2_busy_commit_cycle", wb.rs1_busy, 1);
    tick();
    settle();
    chk("t2_busy_after", wb.rs1_busy, 0);
    chk("t2_rf_wen_drop", wb.rf_wen, 0);
    tick();

    // 3: both valid for 4 cycles -> LSU, ALU, LSU, ALU
    exp_lsu  = '{1, 0, 1, 0};
    exp_data = '{32'hB000, 32'hA000, 32'hB001, 32'hA001};
    ai = 0; li = 0;
    for (int i = 0; i < 4; i++) begin
      wb.alu_valid = 1; wb.alu_rd = 5'(10 + ai); wb.alu_data = 32'hA000 + 32'(ai);
      wb.lsu_valid = 1; wb.lsu_rd = 5'(20 + li); wb.lsu_data = 32'hB000 + 32'(li);
      settle();
      chk("t3_lsu_grant", wb.lsu_ready, exp_lsu[i]);
      chk("t3_alu_grant", wb.alu_ready, !exp_lsu[i]);
      if (i > 0) begin
        chk("t3_rf_wen", wb.rf_wen, 1);
        chk("t3_rf_wdata", wb.rf_wdata, exp_data[i-1]);
      end
      tick();
      if (exp_lsu[i]) li++; else ai++;
    end
    idle();
    settle();
    chk("t3_last_wdata", wb.rf_wdata, exp_data[3]);
    tick();
    settle();
    chk("t3_no_dup", wb.rf_wen, 0);
    tick();

    // 4: LSU writes x0 -> accepted, discarded
    wb.lsu_valid = 1; wb.lsu_rd = '0; wb.lsu_data = 32'h1234;
    wb.issue_en = 1; wb.issue_rd = '0;
    settle();
    chk("t4_lsu_ready", wb.lsu_ready, 1);
    tick();
    idle();
    settle();
    chk("t4_rf_wen", wb.rf_wen, 0);
    chk("t4_busy0", wb.rs1_busy, 0);
    tick();

    // 5: commit of x7 coinciding with a new issue of x7 leaves x7 busy
    wb.issue_en = 1; wb.issue_rd = 5'd7;
    tick();
    idle();
    wb.alu_valid = 1; wb.alu_rd = 5'd7; wb.alu_data = 32'h77;
    tick();
    idle();
    wb.issue_en = 1; wb.issue_rd = 5'd7; wb.rs1_addr = 5'd7;
    settle();
    chk("t5_rf_wen", wb.rf_wen, 1);
    chk("t5_rf_waddr", wb.rf_waddr, 7);
    tick();
    idle();
    wb.rs1_addr = 5'd7;
    settle();
    chk("t5_set_wins", wb.rs1_busy, 1);
    tick();

    // 6: flush clears busy and blocks acceptance for that cycle
    wb.issue_en = 1; wb.issue_rd = 5'd3;
    tick();
    wb.issue_rd = 5'd9;
    tick();
    idle();
    wb.rs1_addr = 5'd3; wb.rs2_addr = 5'd9; wb.flush = 1;
    wb.alu_valid = 1; wb.alu_rd = 5'd4; wb.alu_data = 32'h44;
    settle();
    chk("t6_alu_ready_flush", wb.alu_ready, 0);
    chk("t6_busy3_before", wb.rs1_busy, 1);
    chk("t6_busy9_before", wb.rs2_busy, 1);
    tick();
    wb.flush = 0;
    settle();
    chk("t6_busy3_after", wb.rs1_busy, 0);
    chk("t6_busy9_after", wb.rs2_busy, 0);
    chk("t6_alu_ready_after", wb.alu_ready, 1);
    tick();
    idle();
    wb.rs1_addr = 5'd7;
    settle();
    chk("t6_busy7_cleared", wb.rs1_busy, 0);
    tick();

    // Randomized traffic against the model; sources hold until accepted
    ah = 0; lh = 0;
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(63) == 0);
      wb.flush = ($urandom_range(15) == 0);
      if (!ah) begin
        wb.alu_valid = 1'($urandom_range(1));
        wb.alu_rd    = 5'($urandom_range(7));
        wb.alu_data  = $urandom;
      end
      if (!lh) begin
        wb.lsu_valid = 1'($urandom_range(1));
        wb.lsu_rd    = 5'($urandom_range(7));
        wb.lsu_data  = $urandom;
      end
      wb.issue_en = 1'($urandom_range(1));
      wb.issue_rd = 5'($urandom_range(7));
      wb.rs1_addr = 5'($urandom_range(7));
      wb.rs2_addr = 5'($urandom_range(7));
      tick();
      ah = wb.alu_valid && (m_winner != 1);
      lh = wb.lsu_valid && (m_winner != 2);
    end
    rst = 1'b0;
    idle();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
